// File: rtl/led_blink_ctrl.sv
// LED command controller: OFF / solid ON / continuous blink / counted burst.
// Each LED level lasts the latched half-period; a burst ends with a one-cycle done pulse.
module led_blink_ctrl #(
   parameter int DIV_W = 27,
   parameter int CNT_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [DIV_W-1:0] cmd_half_period,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             led_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SOLID = 2'b01,
      S_BLINK = 2'b10,
      S_BURST = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             led_q, led_d;
   logic             done_q, done_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] hp_q, hp_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;

   logic             accept;
   logic [DIV_W-1:0] hp_last;
   logic [CNT_W-1:0] bcnt_nxt;

   assign cmd_ready = (state_q != S_BURST);
   assign busy      = (state_q == S_BLINK) || (state_q == S_BURST);
   assign led_out   = led_q;
   assign done      = done_q;
   assign accept    = cmd_valid && cmd_ready;
   assign hp_last   = hp_q - DIV_W'(1);
   assign bcnt_nxt  = bcnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      hp_d    = hp_q;
      n_d     = n_q;
      bcnt_d  = bcnt_q;
      if (accept) begin
         // A new command always restarts timing, even mid-phase in BLINK.
         hp_d   = (cmd_half_period == '0) ? DIV_W'(1) : cmd_half_period;
         n_d    = cmd_count;
         cnt_d  = '0;
         bcnt_d = '0;
         case (cmd_mode)
            MODE_OFF: begin
               state_d = S_IDLE;
               led_d   = 1'b0;
            end
            MODE_ON: begin
               state_d = S_SOLID;
               led_d   = 1'b1;
            end
            MODE_BLINK: begin
               state_d = S_BLINK;
               led_d   = 1'b1;
            end
            default: begin
               if (cmd_count == '0) begin
                  state_d = S_IDLE;
                  led_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_BURST;
                  led_d   = 1'b1;
               end
            end
         endcase
      end else if (busy) begin
         if (cnt_q == hp_last) begin
            cnt_d = '0;
            led_d = ~led_q;
            // A burst period is counted when its low half ends.
            if (state_q == S_BURST && !led_q) begin
               bcnt_d = bcnt_nxt;
               if (bcnt_nxt == n_q) begin
                  state_d = S_IDLE;
                  led_d   = 1'b0;
                  done_d  = 1'b1;
                  bcnt_d  = '0;
               end
            end
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         hp_q    <= '0;
         n_q     <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         n_q     <= n_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: stimulus driven and outputs sampled on negedge.
module tb_led_blink_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_mode = 2'b00;
   logic [26:0] cmd_half_period = '0;
   logic [3:0]  cmd_count = '0;
   logic        led_out;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   led_blink_ctrl #(.DIV_W(27), .CNT_W(4)) dut (
      .clk_in          (clk_in),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_mode        (cmd_mode),
      .cmd_half_period (cmd_half_period),
      .cmd_count       (cmd_count),
      .led_out         (led_out),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk_in = ~clk_in;

   // Presents a command for one edge; returns at the negedge after the accepting edge.
   task automatic send(input logic [1:0] m, input logic [26:0] hp, input logic [3:0] n);
      @(negedge clk_in);
      cmd_valid       = 1'b1;
      cmd_mode        = m;
      cmd_half_period = hp;
      cmd_count       = n;
      @(negedge clk_in);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #2;
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL reset_led: got %b expected 0", led_out); end
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   task automatic test_on;
      send(2'b01, 27'd4, 4'd0);
      n_tests++; if (led_out !== 1'b1)   begin n_fail++; $display("FAIL on_led: got %b expected 1", led_out); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL on_ready: got %b expected 1", cmd_ready); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL on_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clk_in);
      n_tests++; if (led_out !== 1'b1)   begin n_fail++; $display("FAIL on_hold_led: got %b expected 1", led_out); end
   endtask

   task automatic test_blink;
      logic exp;
      send(2'b10, 27'd3, 4'd0);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk_in);
         exp = ((i / 3) % 2) == 0;
         n_tests++; if (led_out !== exp) begin n_fail++; $display("FAIL blink_led[%0d]: got %b expected %b", i, led_out, exp); end
         n_tests++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL blink_busy[%0d]: got %b expected 1", i, busy); end
      end
   endtask

   task automatic test_burst;
      logic [7:0] pat;
      pat = 8'b1100_1100;
      send(2'b11, 27'd2, 4'd2);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk_in);
         n_tests++; if (led_out !== pat[7-i]) begin n_fail++; $display("FAIL burst_led[%0d]: got %b expected %b", i, led_out, pat[7-i]); end
         n_tests++; if (cmd_ready !== 1'b0)   begin n_fail++; $display("FAIL burst_ready[%0d]: got %b expected 0", i, cmd_ready); end
         n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL burst_done_early[%0d]: got %b expected 0", i, done); end
      end
      @(negedge clk_in);
      n_tests++; if (done !== 1'b1)      begin n_fail++; $display("FAIL burst_done: got %b expected 1", done); end
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL burst_end_led: got %b expected 0", led_out); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL burst_end_ready: got %b expected 1", cmd_ready); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL burst_end_busy: got %b expected 0", busy); end
      @(negedge clk_in);
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL burst_done_width: got %b expected 0", done); end
   endtask

   task automatic test_zero;
      logic exp;
      send(2'b11, 27'd5, 4'd0);
      n_tests++; if (done !== 1'b1)    begin n_fail++; $display("FAIL n0_done: got %b expected 1", done); end
      n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL n0_led: got %b expected 0", led_out); end
      n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL n0_busy: got %b expected 0", busy); end
      @(negedge clk_in);
      n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL n0_done_width: got %b expected 0", done); end
      send(2'b11, 27'd0, 4'd0);
      n_tests++; if (done !== 1'b1)    begin n_fail++; $display("FAIL hp0n0_done: got %b expected 1", done); end
      n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL hp0n0_led: got %b expected 0", led_out); end
      send(2'b11, 27'd0, 4'd1);
      n_tests++; if (led_out !== 1'b1) begin n_fail++; $display("FAIL hp0n1_led0: got %b expected 1", led_out); end
      @(negedge clk_in);
      n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL hp0n1_led1: got %b expected 0", led_out); end
      n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL hp0n1_early: got %b expected 0", done); end
      @(negedge clk_in);
      n_tests++; if (done !== 1'b1)    begin n_fail++; $display("FAIL hp0n1_done: got %b expected 1", done); end
      n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL hp0n1_end_led: got %b expected 0", led_out); end
      send(2'b10, 27'd0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk_in);
         exp = (i % 2) == 0;
         n_tests++; if (led_out !== exp) begin n_fail++; $display("FAIL hp0_blink[%0d]: got %b expected %b", i, led_out, exp); end
      end
   endtask

   task automatic test_off_mid_blink;
      send(2'b10, 27'd5, 4'd2);
      repeat (2) @(negedge clk_in);
      n_tests++; if (led_out !== 1'b1) begin n_fail++; $display("FAIL off_pre_led: got %b expected 1", led_out); end
      send(2'b00, 27'd5, 4'd2);
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL off_led: got %b expected 0", led_out); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL off_busy: got %b expected 0", busy); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL off_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_held_during_burst;
      send(2'b11, 27'd1, 4'd1);
      cmd_valid = 1'b1;
      cmd_mode  = 2'b01;
      n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready0: got %b expected 0", cmd_ready); end
      @(negedge clk_in);
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL hold_led1: got %b expected 0", led_out); end
      n_tests++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL hold_busy1: got %b expected 1", busy); end
      @(negedge clk_in);
      n_tests++; if (done !== 1'b1)      begin n_fail++; $display("FAIL hold_done: got %b expected 1", done); end
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL hold_done_led: got %b expected 0", led_out); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold_done_ready: got %b expected 1", cmd_ready); end
      @(negedge clk_in);
      cmd_valid = 1'b0;
      n_tests++; if (led_out !== 1'b1)   begin n_fail++; $display("FAIL hold_accept_led: got %b expected 1", led_out); end
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL hold_accept_done: got %b expected 0", done); end
   endtask

   task automatic test_reset_mid_burst;
      send(2'b11, 27'd2, 4'd3);
      repeat (4) @(negedge clk_in);
      n_tests++; if (led_out !== 1'b1) begin n_fail++; $display("FAIL rstb_pre_led: got %b expected 1", led_out); end
      n_tests++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL rstb_pre_busy: got %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (led_out !== 1'b0)   begin n_fail++; $display("FAIL rstb_led: got %b expected 0", led_out); end
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstb_ready: got %b expected 1", cmd_ready); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstb_busy: got %b expected 0", busy); end
      @(negedge clk_in);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_in);
         n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rstb_done[%0d]: got %b expected 0", i, done); end
         n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL rstb_after_led[%0d]: got %b expected 0", i, led_out); end
         n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstb_after_busy[%0d]: got %b expected 0", i, busy); end
      end
   endtask

   initial begin
      test_reset;
      test_on;
      test_blink;
      test_burst;
      test_zero;
      test_off_mid_blink;
      test_held_during_burst;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 27: width of the half-period field and the cycle counter.
REQ-002 SHALL have parameter CNT_W, default 4: width of the burst-count field.
REQ-003 SHALL have port clk_in, input, 1: single system clock (100 MHz nominal); all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command request.
REQ-006 SHALL have port cmd_ready, output, 1: controller can accept a command.
REQ-007 SHALL have port cmd_mode, input, 2: 00 OFF, 01 ON, 10 BLINK (continuous), 11 BURST.
REQ-008 SHALL have port cmd_half_period, input, DIV_W: clk_in cycles per LED half-period.
REQ-009 SHALL have port cmd_count, input, CNT_W: number of on/off periods in BURST.
REQ-010 SHALL have port led_out, output, 1: registered LED drive.
REQ-011 SHALL have port busy, output, 1: high in BLINK or BURST state.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at BURST completion.

Function
REQ-013 SHALL implement states IDLE, SOLID, BLINK, BURST.
REQ-014 SHALL assert cmd_ready in IDLE, SOLID and BLINK; deassert in BURST.
REQ-015 SHALL accept a command on a posedge where cmd_valid && cmd_ready; mode, half-period and count are latched at acceptance.
REQ-016 SHALL, on accept of OFF: go to IDLE, led_out=0 next cycle.
REQ-017 SHALL, on accept of ON: go to SOLID, led_out=1 next cycle.
REQ-018 SHALL, on accept of BLINK or BURST: clear the cycle counter, led_out=1 next cycle, enter BLINK or BURST.
REQ-019 SHALL treat latched half-period 0 as 1.
REQ-020 SHALL count cycles 0..HP-1 in BLINK/BURST; at count==HP-1, wrap to 0 and toggle led_out, so each level lasts exactly HP cycles.
REQ-021 SHALL, in BURST, count completed low half-periods; at the edge ending the Nth low half-period, pulse done for one cycle, go to IDLE, and keep led_out=0.
REQ-022 SHALL, on accept of BURST with count 0: pulse done the next cycle, stay in IDLE, led_out=0.
REQ-023 SHALL, on a new command accepted while in BLINK, abandon the current phase immediately, with no wait for a period boundary.
REQ-024 SHALL ignore cmd_valid while in BURST; the command is held off by cmd_ready=0, never dropped or queued.
REQ-025 SHALL, when done pulses and cmd_valid is high in the same cycle, accept the command on the following edge, not the completion edge.
REQ-026 SHALL drive busy combinationally from state.
REQ-027 SHALL keep the counter and burst counter from overflowing, holding them within range by wrap at HP-1 and N.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, led_out=0, done=0, and clear all counters and latched fields.
REQ-029 SHALL drive cmd_ready=1 and busy=0 during reset.
REQ-030 SHALL, on rst_n deassertion mid-BLINK or mid-BURST, resume in IDLE with no done pulse.

Verification
REQ-031 SHALL verify: reset, then ON accepted at edge k -> led_out=1 from k+1, cmd_ready stays 1.
REQ-032 SHALL verify: BLINK with HP=3 -> led_out 1,1,1,0,0,0,1... repeating; busy=1 throughout.
REQ-033 SHALL verify: BURST with HP=2, N=2 -> led_out 1,1,0,0,1,1,0,0; done pulses on the 8th edge; cmd_ready=0 for 8 cycles, then 1.
REQ-034 SHALL verify: BURST with N=0, and separately with HP=0 -> done next cycle, led_out=0; and HP=0 BLINK toggles every cycle.
REQ-035 SHALL verify: OFF issued mid-BLINK at HP=5, count 2 -> led_out=0 next cycle, busy=0; and cmd_valid held during BURST is accepted only after done.
REQ-036 SHALL verify: rst_n pulsed low mid-BURST -> led_out=0 asynchronously, no done pulse, cmd_ready=1.
